dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares the single-port data memory between the pipeline memory stage
// (port P) and the test/loader DMA port (port D). Each transaction takes
// two cycles:
//   ISSUE: the memory is driven from the latched request.
//   RESP:  the winner receives done/err/rdata.
// Requests are sampled only at the end of IDLE and RESP. A request whose
// address is misaligned or past the end of the array is rejected: the
// memory is never enabled for it, and it completes with err = 1.
//
// Ports:
//   clk, reset                        rising-edge clock, synchronous active-high reset
//   p_req/p_we/p_addr/p_wdata         port P request (write when we = 1)
//   p_gnt/p_done/p_err/p_rdata        port P issue strobe and completion
//   d_*                               same as p_*, for port D
//   mem_read/mem_write                data memory enables (only ever high in ISSUE)
//   mem_address/mem_write_data        latched request address and data
//   mem_read_data                     registered memory output, valid in RESP
//   busy                              high whenever the sequencer is not idle
module dmem_port_arbiter #(
  parameter int WORD  = 64,
  parameter int DEPTH = 100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p_req,
  input  logic            p_we,
  input  logic [WORD-1:0] p_addr,
  input  logic [WORD-1:0] p_wdata,
  output logic            p_gnt,
  output logic            p_done,
  output logic            p_err,
  output logic [WORD-1:0] p_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_done,
  output logic            d_err,
  output logic [WORD-1:0] d_rdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_address,
  output logic [WORD-1:0] mem_write_data,
  input  logic [WORD-1:0] mem_read_data,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [WORD-1:0] DEPTH_W = WORD'(DEPTH);

  state_t          state_reg;
  logic            last_gnt_d_reg;  // 1: most recent grant went to D
  logic            win_d_reg;       // owner of the transaction in flight
  logic            we_reg;
  logic [WORD-1:0] addr_reg;
  logic [WORD-1:0] wdata_reg;
  logic            p_gnt_reg;
  logic            d_gnt_reg;
  logic            p_done_reg;
  logic            d_done_reg;
  logic            err_reg;
  logic            rd_ok_reg;       // completion carries memory read data

  logic            addr_ok;
  logic            win_d_next;

  // Range check is done on the word index, so addresses with high bits set
  // are rejected outright instead of wrapping into the array.
  assign addr_ok = (addr_reg[2:0] == 3'b000) && ((addr_reg >> 3) < DEPTH_W);

  // D wins when it is the only requester, or on a tie when P was granted last.
  assign win_d_next = d_req & (~p_req | ~last_gnt_d_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_gnt_d_reg <= 1'b1;
      win_d_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      p_gnt_reg      <= 1'b0;
      d_gnt_reg      <= 1'b0;
      p_done_reg     <= 1'b0;
      d_done_reg     <= 1'b0;
      err_reg        <= 1'b0;
      rd_ok_reg      <= 1'b0;
    end else begin
      p_gnt_reg  <= 1'b0;
      d_gnt_reg  <= 1'b0;
      p_done_reg <= 1'b0;
      d_done_reg <= 1'b0;
      case (state_reg)
        IDLE, RESP: begin
          if (p_req || d_req) begin
            state_reg      <= ISSUE;
            win_d_reg      <= win_d_next;
            last_gnt_d_reg <= win_d_next;
            we_reg         <= win_d_next ? d_we    : p_we;
            addr_reg       <= win_d_next ? d_addr  : p_addr;
            wdata_reg      <= win_d_next ? d_wdata : p_wdata;
            p_gnt_reg      <= ~win_d_next;
            d_gnt_reg      <= win_d_next;
          end else begin
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          state_reg  <= RESP;
          p_done_reg <= ~win_d_reg;
          d_done_reg <= win_d_reg;
          err_reg    <= ~addr_ok;
          rd_ok_reg  <= addr_ok & ~we_reg;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_read       = (state_reg == ISSUE) & addr_ok & ~we_reg;
  assign mem_write      = (state_reg == ISSUE) & addr_ok & we_reg;
  assign mem_address    = addr_reg;
  assign mem_write_data = wdata_reg;

  assign p_gnt   = p_gnt_reg;
  assign d_gnt   = d_gnt_reg;
  assign p_done  = p_done_reg;
  assign d_done  = d_done_reg;
  assign p_err   = p_done_reg & err_reg;
  assign d_err   = d_done_reg & err_reg;
  // Memory output goes straight through during RESP.
  assign p_rdata = (p_done_reg & rd_ok_reg) ? mem_read_data : '0;
  assign d_rdata = (d_done_reg & rd_ok_reg) ? mem_read_data : '0;

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter.
// A registered-read data memory sits on the mem_* port. A transaction-level
// reference model schedules, for each accepted request, the expected
// outputs in the grant cycle and the completion cycle. The model keeps its
// own shadow copy of memory for the expected read data.
module tb_dmem_port_arbiter;
  localparam int WORD  = 64;
  localparam int DEPTH = 100;
  localparam int MAXC  = 4096;

  logic            clk = 1'b0;
  logic            reset;
  logic            p_req, p_we, d_req, d_we;
  logic [WORD-1:0] p_addr, p_wdata, d_addr, d_wdata;
  logic            p_gnt, p_done, p_err, d_gnt, d_done, d_err;
  logic [WORD-1:0] p_rdata, d_rdata;
  logic            mem_read, mem_write, busy;
  logic [WORD-1:0] mem_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_done(p_done), .p_err(p_err), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Data memory attached to the arbiter.
  bit [63:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_read)
      mem_read_data <= ((mem_address >> 3) < 64'(DEPTH)) ? env_mem[int'(mem_address >> 3)]
                                                        : 64'hDEAD_BEEF_DEAD_BEEF;
    if (mem_write && ((mem_address >> 3) < 64'(DEPTH)))
      env_mem[int'(mem_address >> 3)] = mem_write_data;
  end

  // Reference model: shadow memory plus per-cycle expectation tables.
  bit [63:0] ref_mem [DEPTH];
  bit        e_pg [MAXC], e_dg [MAXC], e_pd [MAXC], e_dd [MAXC];
  bit        e_pe [MAXC], e_de [MAXC], e_mr [MAXC], e_mw [MAXC];
  bit        e_busy [MAXC], e_chk [MAXC];
  bit [63:0] e_prd [MAXC], e_drd [MAXC], e_addr [MAXC], e_wd [MAXC];

  int cyc = 0;
  int next_sample = 0;
  bit last_d = 1'b1;
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_cycle(input int k);
    e_pg[k] = 0; e_dg[k] = 0; e_pd[k] = 0; e_dd[k] = 0;
    e_pe[k] = 0; e_de[k] = 0; e_mr[k] = 0; e_mw[k] = 0;
    e_busy[k] = 0; e_chk[k] = 0;
    e_prd[k] = 0; e_drd[k] = 0; e_addr[k] = 0; e_wd[k] = 0;
  endtask

  // Apply one cycle of inputs, update the model, advance one clock, then
  // compare every output in the new cycle.
  task automatic step(input bit pr, input bit pwe, input logic [63:0] pa, input logic [63:0] pw,
                      input bit dr, input bit dwe, input logic [63:0] da, input logic [63:0] dw,
                      input bit rst);
    bit        wd, we, ok;
    logic [63:0] a, w, rd;
    int        c1, c2;
    reset = rst;
    p_req = pr; p_we = pwe; p_addr = pa; p_wdata = pw;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
    c1 = cyc + 1;
    c2 = cyc + 2;
    if (rst) begin
      clear_cycle(c1);
      clear_cycle(c2);
      last_d = 1'b1;
      next_sample = c1;
      e_chk[c1] = 1;
    end else if (cyc == next_sample) begin
      if (pr || dr) begin
        wd = (pr && dr) ? !last_d : dr;
        last_d = wd;
        we = wd ? dwe : pwe;
        a  = wd ? da : pa;
        w  = wd ? dw : pw;
        ok = (a % 8 == 0) && (a / 8 < 64'(DEPTH));
        rd = 0;
        if (ok && !we) rd = ref_mem[int'(a / 8)];
        if (ok && we) ref_mem[int'(a / 8)] = w;
        if (wd) begin
          e_dg[c1] = 1; e_dd[c2] = 1; e_de[c2] = !ok; e_drd[c2] = rd;
        end else begin
          e_pg[c1] = 1; e_pd[c2] = 1; e_pe[c2] = !ok; e_prd[c2] = rd;
        end
        e_busy[c1] = 1; e_busy[c2] = 1;
        e_mr[c1] = ok && !we;
        e_mw[c1] = ok && we;
        e_chk[c1] = 1; e_addr[c1] = a; e_wd[c1] = w;
        next_sample = c2;
      end else begin
        next_sample = c1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_val("p_gnt",   64'(p_gnt),   64'(e_pg[cyc]));
    check_val("d_gnt",   64'(d_gnt),   64'(e_dg[cyc]));
    check_val("p_done",  64'(p_done),  64'(e_pd[cyc]));
    check_val("d_done",  64'(d_done),  64'(e_dd[cyc]));
    check_val("p_err",   64'(p_err),   64'(e_pe[cyc]));
    check_val("d_err",   64'(d_err),   64'(e_de[cyc]));
    check_val("p_rdata", p_rdata,      e_prd[cyc]);
    check_val("d_rdata", d_rdata,      e_drd[cyc]);
    check_val("mem_read",  64'(mem_read),  64'(e_mr[cyc]));
    check_val("mem_write", 64'(mem_write), 64'(e_mw[cyc]));
    check_val("rd_wr_overlap", 64'(mem_read & mem_write), 64'(0));
    check_val("busy", 64'(busy), 64'(e_busy[cyc]));
    if (e_chk[cyc]) begin
      check_val("mem_address",    mem_address,    e_addr[cyc]);
      check_val("mem_write_data", mem_write_data, e_wd[cyc]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 11);
    if (r <= 5)       return 64'(8 * $urandom_range(0, 7));
    else if (r <= 7)  return 64'(8 * $urandom_range(DEPTH - 4, DEPTH - 1));
    else if (r == 8)  return 64'(8 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 7));
    else if (r == 9)  return 64'(8 * DEPTH + 8 * $urandom_range(0, 3));
    else if (r == 10) return 64'hFFFF_FFFF_FFFF_FFF8;
    else              return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] r1, r2;
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = 64'(i) * 64'h0101_0101 + 64'h7700;
      ref_mem[i] = env_mem[i];
    end
    env_mem[3] = 64'hA5;
    ref_mem[3] = 64'hA5;
    reset = 1'b1;
    p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    do_reset();
    do_reset();
    idle(2);

    // Single read on P from word 3.
    step(1, 0, 24, 0, 0, 0, 0, 0, 0);
    idle(3);

    // D write then back-to-back read of the same word.
    step(0, 0, 0, 0, 1, 1, 16, 64'h1234, 0);
    step(0, 0, 0, 0, 1, 0, 16, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Both ports requesting continuously after reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      step(1, i[1], 64'(8 * i), r1, 1, ~i[1], 64'(8 * i + 32), r2, 0);
    end
    idle(3);

    // Rejected accesses: misaligned read, out-of-range write, wrap attempt.
    step(1, 0, 12, 0, 1, 1, 800, 64'h55, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h66, 0, 0, 0, 0, 0);
    idle(3);

    // Last valid word.
    step(1, 1, 792, 64'hFF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 792, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Reset in the RESP cycle of a P read, then a tie.
    step(1, 0, 40, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 48, 0, 1, 0, 56, 0, 0);
    step(1, 0, 48, 0, 1, 0, 56, 0, 0);
    idle(4);

    // Reset in the ISSUE cycle of a D write: the write still lands.
    step(0, 0, 0, 0, 1, 1, 64, 64'hC0DE, 0);
    do_reset();
    step(1, 0, 64, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rand_addr(), {$urandom, $urandom},
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rand_addr(), {$urandom, $urandom},
           $urandom_range(0, 79) == 0);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
